// File: rtl/stack_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : stack_sequencer_if
//  Description : Request / data-memory / pipeline-control bundle of the
//                stack sequencer. The slave modport is the sequencer view and
//                the master modport is the view of the surrounding core.
//                Names are prefixed from the sequencer's point of view
//                (i_ = into the sequencer, o_ = out of it).
//  Revision    : 1.0  initial release
// ============================================================================
interface stack_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              i_start;      // one-cycle request
    logic [1:0]        i_op;         // 00 CALL, 01 RET, 10 INT, 11 RTI
    logic [31:0]       i_pc_in;      // PC to push
    logic [4:0]        i_ccr_in;     // flags to push
    logic [DATA_W-1:0] i_mem_rdata;  // read data, one cycle after the read
    logic              o_mem_en;
    logic              o_mem_rw;     // 1 = write
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [31:0]       o_sp_out;
    logic              o_stall;
    logic              o_busy;
    logic              o_pc_load;
    logic [31:0]       o_pc_out;
    logic              o_ccr_load;
    logic [4:0]        o_ccr_out;
    logic              o_done;

    modport slave (
        input  i_start, i_op, i_pc_in, i_ccr_in, i_mem_rdata,
        output o_mem_en, o_mem_rw, o_mem_addr, o_mem_wdata, o_sp_out,
               o_stall, o_busy, o_pc_load, o_pc_out, o_ccr_load,
               o_ccr_out, o_done
    );

    modport master (
        output i_start, i_op, i_pc_in, i_ccr_in, i_mem_rdata,
        input  o_mem_en, o_mem_rw, o_mem_addr, o_mem_wdata, o_sp_out,
               o_stall, o_busy, o_pc_load, o_pc_out, o_ccr_load,
               o_ccr_out, o_done
    );
endinterface
`default_nettype wire

// File: rtl/stack_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : stack_sequencer
//  Description : Multi-cycle controller owning the data-memory port for
//                32-bit stack transfers. CALL/INT push PC (and CCR for INT),
//                RET/RTI pop them back, one 16-bit word per cycle. Owns the
//                stack pointer and stalls fetch/decode while it runs.
//  Ports       : clk    - clock, rising edge
//                reset  - asynchronous, active-high
//                bus    - stack_sequencer_if.slave:
//                         i_start/i_op/i_pc_in/i_ccr_in request (IDLE only)
//                         i_mem_rdata, o_mem_en/rw/addr/wdata memory port
//                         o_sp_out current SP, o_stall, o_busy (registered)
//                         o_pc_load/o_pc_out, o_ccr_load/o_ccr_out popped
//                         values, o_done final-cycle pulse
//  Revision    : 1.0  initial release
// ============================================================================
module stack_sequencer #(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] SP_RESET = 32'h0000_0FFF
) (
    input  wire logic            clk,
    input  wire logic            reset,
    stack_sequencer_if.slave     bus
);

    localparam logic [1:0] c_OP_CALL = 2'b00;
    localparam logic [1:0] c_OP_RET  = 2'b01;
    localparam logic [1:0] c_OP_INT  = 2'b10;
    localparam logic [1:0] c_OP_RTI  = 2'b11;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        PUSH_HI  = 4'd1,
        PUSH_LO  = 4'd2,
        PUSH_CCR = 4'd3,
        POP_CCR  = 4'd4,
        POP_LO   = 4'd5,
        POP_HI   = 4'd6,
        FINISH   = 4'd7,
        DONE     = 4'd8
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_sp;
    logic [1:0]         r_op;
    logic [31:0]        r_pc;
    logic [4:0]         r_ccr;
    logic [31:0]        r_pc_out;
    logic [4:0]         r_ccr_out;
    logic               r_busy;

    logic [31:0]        w_sp_inc;
    logic               w_is_push;
    logic               w_is_pop;
    logic               w_mem_en;
    logic               w_mem_rw;
    logic [ADDR_W-1:0]  w_mem_addr;
    logic [DATA_W-1:0]  w_mem_wdata;
    logic               w_done;
    logic               w_pc_load;
    logic               w_ccr_load;

    // Pops pre-increment: the read address is the slot just above SP.
    assign w_sp_inc  = r_sp + 32'd1;
    assign w_is_push = (r_state == PUSH_HI) || (r_state == PUSH_LO) ||
                       (r_state == PUSH_CCR);
    assign w_is_pop  = (r_state == POP_CCR) || (r_state == POP_LO) ||
                       (r_state == POP_HI);

    // ------------------------------------------------------------------
    // Next-state and Moore-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_mem_en    = 1'b0;
        w_mem_rw    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_done      = 1'b0;
        w_pc_load   = 1'b0;
        w_ccr_load  = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    case (bus.i_op)
                        c_OP_CALL: w_next = PUSH_HI;
                        c_OP_INT:  w_next = PUSH_HI;
                        c_OP_RET:  w_next = POP_LO;
                        default:   w_next = POP_CCR;
                    endcase
                end
            end
            PUSH_HI: begin
                w_next      = PUSH_LO;
                w_mem_wdata = r_pc[31:16];
            end
            PUSH_LO: begin
                w_next      = (r_op == c_OP_INT) ? PUSH_CCR : DONE;
                w_mem_wdata = r_pc[15:0];
            end
            PUSH_CCR: begin
                w_next      = DONE;
                w_mem_wdata = {{(DATA_W-5){1'b0}}, r_ccr};
            end
            POP_CCR:  w_next = POP_LO;
            POP_LO:   w_next = POP_HI;
            POP_HI:   w_next = FINISH;
            FINISH:   w_next = DONE;
            DONE: begin
                w_next     = IDLE;
                w_done     = 1'b1;
                w_pc_load  = (r_op == c_OP_RET) || (r_op == c_OP_RTI);
                w_ccr_load = (r_op == c_OP_RTI);
            end
            default:  w_next = IDLE;
        endcase

        if (w_is_push) begin
            w_mem_en   = 1'b1;
            w_mem_rw   = 1'b1;
            w_mem_addr = r_sp[ADDR_W-1:0];
        end else if (w_is_pop) begin
            w_mem_en   = 1'b1;
            w_mem_rw   = 1'b0;
            w_mem_addr = w_sp_inc[ADDR_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // State, SP, request latches and pop captures
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_sp      <= SP_RESET;
            r_op      <= 2'b00;
            r_pc      <= 32'd0;
            r_ccr     <= 5'd0;
            r_pc_out  <= 32'd0;
            r_ccr_out <= 5'd0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);

            if ((r_state == IDLE) && bus.i_start) begin
                r_op  <= bus.i_op;
                r_pc  <= bus.i_pc_in;
                r_ccr <= bus.i_ccr_in;
            end

            // SP wraps modulo 2^32 in both directions.
            if (w_is_push) begin
                r_sp <= r_sp - 32'd1;
            end else if (w_is_pop) begin
                r_sp <= w_sp_inc;
            end

            // Read data lags its address by one state, so each word is
            // captured at the end of the state after the one that read it.
            if ((r_state == POP_LO) && (r_op == c_OP_RTI)) begin
                r_ccr_out <= bus.i_mem_rdata[4:0];
            end
            if (r_state == POP_HI) begin
                r_pc_out[15:0] <= bus.i_mem_rdata;
            end
            if (r_state == FINISH) begin
                r_pc_out[31:16] <= bus.i_mem_rdata;
            end
        end
    end

    assign bus.o_mem_en    = w_mem_en;
    assign bus.o_mem_rw    = w_mem_rw;
    assign bus.o_mem_addr  = w_mem_addr;
    assign bus.o_mem_wdata = w_mem_wdata;
    assign bus.o_sp_out    = r_sp;
    // Combinational on start so fetch freezes in the request cycle itself.
    assign bus.o_stall     = (bus.i_start && (r_state == IDLE)) || (r_state != IDLE);
    assign bus.o_busy      = r_busy;
    assign bus.o_pc_load   = w_pc_load;
    assign bus.o_pc_out    = r_pc_out;
    assign bus.o_ccr_load  = w_ccr_load;
    assign bus.o_ccr_out   = r_ccr_out;
    assign bus.o_done      = w_done;

endmodule
`default_nettype wire
